// File: rtl/fr_diag_pkg.sv
// Shared definitions for the floppy/drive diagnostic telemetry blocks:
// record framing constants, counter indices and the record emitter states.
package fr_diag_pkg;

    localparam logic [7:0] REC_MAGIC = 8'hEC;
    localparam int         NUM_CNT   = 9;
    localparam int         REC_WORDS = NUM_CNT + 2;

    localparam logic [7:0] NUM_CNT_B = 8'(NUM_CNT);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_CNT);
    localparam logic [6:0] DROP_MAX  = 7'd127;

    localparam int CNT_CRC_DATA    = 0;
    localparam int CNT_CRC_ADDR    = 1;
    localparam int CNT_MISSING_AM  = 2;
    localparam int CNT_MISSING_DAM = 3;
    localparam int CNT_OVERRUN     = 4;
    localparam int CNT_UNDERRUN    = 5;
    localparam int CNT_SEEK        = 6;
    localparam int CNT_WRITE_FAULT = 7;
    localparam int CNT_PLL_UNLOCK  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        CNT  = 2'd2,
        SUM  = 2'd3
    } rec_state_t;

    function automatic logic [31:0] make_header(input logic [7:0] seq,
                                                input logic       clr,
                                                input logic [6:0] dropped);
        return {REC_MAGIC, seq, NUM_CNT_B, clr, dropped};
    endfunction

endpackage

// File: rtl/diag_tick_gen.sv
// Free-running periodic tick for diagnostic reporters; PERIOD_CYCLES=0
// keeps the counter and the tick parked at zero.
module diag_tick_gen #(
    parameter int unsigned PERIOD_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam bit          ENABLE = (PERIOD_CYCLES != 0);
    localparam logic [31:0] RELOAD = ENABLE ? 32'(PERIOD_CYCLES - 1) : 32'd0;

    logic [31:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!ENABLE) begin
            count <= '0;
        end else if (count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 32'd1;
        end
    end

    assign tick = ENABLE && (count == '0);

endmodule

// File: rtl/error_stats_reader.sv
// Snapshots the error counter bank coherently and streams it as an
// 11-word framed, checksummed record over a valid/ready interface.
module error_stats_reader
    import fr_diag_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [32*NUM_CNT-1:0]  cnt_flat,
    input  logic                   snap_req,
    input  logic                   clr_on_read,
    output logic                   clear_all,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic [7:0]             seq_num
);

    rec_state_t  state;
    logic [31:0] snap [NUM_CNT];
    logic [3:0]  word_idx;
    logic [31:0] sum;
    logic [31:0] next_cnt;
    logic        tick;
    logic        pending;
    logic [6:0]  dropped;
    logic [6:0]  drop_rpt;

    logic new_req;
    logic capture;
    logic accept;
    logic busy_req;
    logic sum_xfer;

    diag_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign busy     = (state != IDLE);
    assign new_req  = snap_req | tick;
    assign capture  = (state == IDLE) && (new_req || pending);
    assign accept   = out_valid && out_ready;
    assign busy_req = busy && new_req;
    assign sum_xfer = (state == SUM) && accept;

    always_comb begin
        next_cnt = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (word_idx == 4'(i)) next_cnt = snap[i];
        end
    end

    // Drops seen while record N is in flight are handed over to the header
    // of record N+1 at N's final transfer, when the live counter restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            dropped  <= '0;
            drop_rpt <= '0;
        end else begin
            if (capture) begin
                pending  <= 1'b0;
                drop_rpt <= '0;
            end else if (busy_req) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else if (dropped != DROP_MAX) begin
                    dropped <= dropped + 7'd1;
                end
            end
            if (sum_xfer) begin
                dropped <= '0;
                if (busy_req && pending && dropped != DROP_MAX) begin
                    drop_rpt <= dropped + 7'd1;
                end else begin
                    drop_rpt <= dropped;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            word_idx  <= '0;
            sum       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            clear_all <= 1'b0;
            seq_num   <= '0;
            for (int i = 0; i < NUM_CNT; i++) snap[i] <= '0;
        end else begin
            clear_all <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        for (int i = 0; i < NUM_CNT; i++) begin
                            snap[i] <= cnt_flat[32*i +: 32];
                        end
                        clear_all <= clr_on_read;
                        out_data  <= make_header(seq_num, clr_on_read, drop_rpt);
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        sum       <= '0;
                        word_idx  <= '0;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        sum      <= sum + out_data;
                        out_data <= next_cnt;
                        word_idx <= word_idx + 4'd1;
                        state    <= CNT;
                    end
                end
                CNT: begin
                    if (accept) begin
                        sum <= sum + out_data;
                        if (word_idx == LAST_IDX) begin
                            // Checksum makes the whole record sum to zero.
                            out_data <= 32'd0 - (sum + out_data);
                            out_last <= 1'b1;
                            state    <= SUM;
                        end else begin
                            out_data <= next_cnt;
                            word_idx <= word_idx + 4'd1;
                        end
                    end
                end
                SUM: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        seq_num   <= seq_num + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_error_stats_reader.sv
// Scoreboard bench for error_stats_reader: a second instance with a
// 100-cycle period exercises the timer path and sequence wrap.
module tb_error_stats_reader;
    import fr_diag_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          reset_n2;
    logic [287:0]  cnt_flat;
    logic          snap_req;
    logic          clr_on_read;
    logic          out_ready;
    logic          clear_all;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic [7:0]    seq_num;

    logic          snap_req2;
    logic          clr_on_read2;
    logic          out_ready2;
    logic          clear_all2;
    logic [31:0]   out_data2;
    logic          out_valid2;
    logic          out_last2;
    logic          busy2;
    logic [7:0]    seq_num2;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data_q [$];
    logic        exp_last_q [$];
    logic [7:0]  seq_model;
    logic [31:0] cnt_model [9];

    error_stats_reader #(.PERIOD_CYCLES(0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cnt_flat    (cnt_flat),
        .snap_req    (snap_req),
        .clr_on_read (clr_on_read),
        .clear_all   (clear_all),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .seq_num     (seq_num)
    );

    error_stats_reader #(.PERIOD_CYCLES(100)) dut_periodic (
        .clk         (clk),
        .reset_n     (reset_n2),
        .cnt_flat    (cnt_flat),
        .snap_req    (snap_req2),
        .clr_on_read (clr_on_read2),
        .clear_all   (clear_all2),
        .out_data    (out_data2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_last    (out_last2),
        .busy        (busy2),
        .seq_num     (seq_num2)
    );

    task automatic set_counters(input logic [31:0] base, input bit rnd);
        for (int i = 0; i < 9; i++) begin
            cnt_model[i] = rnd ? 32'($urandom) : base + 32'(i);
            cnt_flat[32*i +: 32] = cnt_model[i];
        end
    endtask

    task automatic push_record(input logic [7:0] seq, input logic clr, input logic [6:0] drp);
        logic [31:0] w;
        logic [31:0] acc;
        w = {8'hEC, seq, 8'd9, clr, drp};
        acc = w;
        exp_data_q.push_back(w);
        exp_last_q.push_back(1'b0);
        for (int i = 0; i < 9; i++) begin
            exp_data_q.push_back(cnt_model[i]);
            exp_last_q.push_back(1'b0);
            acc = acc + cnt_model[i];
        end
        exp_data_q.push_back(32'd0 - acc);
        exp_last_q.push_back(1'b1);
    endtask

    task automatic wait_drain(input int bound, input bit rnd_ready, output bit ok);
        int n;
        n = 0;
        while (exp_data_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        out_ready = 1'b1;
        ok = (exp_data_q.size() == 0);
    endtask

    // Scoreboard monitor: pops on every accepted word, checks hold under stall.
    logic        stalled;
    logic [31:0] stall_data;
    logic        stall_last;
    logic [31:0] word_sum;
    logic [31:0] ed;
    logic        el;

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled  = 1'b0;
            word_sum = '0;
        end else begin
            if (stalled) begin
                checks++;
                if (!out_valid) begin
                    errors++;
                    $display("[TB] FAIL stall_valid_drop: out_valid=%b required 1", out_valid);
                end else if (out_data !== stall_data || out_last !== stall_last) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: data=%h last=%b required data=%h last=%b",
                             out_data, out_last, stall_data, stall_last);
                end
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_word: data=%h required no transfer", out_data);
                end else begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (out_data !== ed || out_last !== el) begin
                        errors++;
                        $display("[TB] FAIL word: data=%h last=%b required data=%h last=%b",
                                 out_data, out_last, ed, el);
                    end
                end
                word_sum = word_sum + out_data;
                if (out_last) begin
                    checks++;
                    if (word_sum !== 32'd0) begin
                        errors++;
                        $display("[TB] FAIL record_sum: sum=%h required 00000000", word_sum);
                    end
                    word_sum = '0;
                end
            end else if (out_valid) begin
                stalled    = 1'b1;
                stall_data = out_data;
                stall_last = out_last;
            end
        end
    end

    task automatic test_reset();
        reset_n      = 1'b0;
        reset_n2     = 1'b0;
        cnt_flat     = '0;
        snap_req     = 1'b0;
        clr_on_read  = 1'b0;
        out_ready    = 1'b1;
        snap_req2    = 1'b0;
        clr_on_read2 = 1'b0;
        out_ready2   = 1'b1;
        seq_model    = 8'd0;
        #22;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0 ||
            clear_all !== 1'b0 || busy !== 1'b0 || seq_num !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: valid=%b last=%b data=%h clr=%b busy=%b seq=%0d required all 0",
                     out_valid, out_last, out_data, clear_all, busy, seq_num);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        set_counters(32'd1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b1;
        push_record(seq_model, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hEC000900 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL header_latency: valid=%b data=%h busy=%b required 1 ec000900 1",
                     out_valid, out_data, busy);
        end
        wait_drain(60, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL basic_drain: %0d words left required 0", exp_data_q.size());
        end
        seq_model = seq_model + 8'd1;
        checks++;
        if (seq_num !== seq_model || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_seq: seq=%0d valid=%b required %0d 0", seq_num, out_valid, seq_model);
        end
    endtask

    task automatic test_stall();
        bit ok;
        for (int r = 0; r < 3; r++) begin
            set_counters(32'd0, 1'b1);
            @(posedge clk);
            #1;
            snap_req = 1'b1;
            push_record(seq_model, 1'b0, 7'd0);
            @(posedge clk);
            #1;
            snap_req = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            wait_drain(400, 1'b1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL stall_drain: %0d words left required 0", exp_data_q.size());
            end
            @(posedge clk);
            #1;
            seq_model = seq_model + 8'd1;
            checks++;
            if (seq_num !== seq_model) begin
                errors++;
                $display("[TB] FAIL stall_seq: seq=%0d required %0d", seq_num, seq_model);
            end
        end
    endtask

    task automatic test_clr_on_read();
        bit ok;
        set_counters(32'd0, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        snap_req    = 1'b1;
        clr_on_read = 1'b1;
        push_record(seq_model, 1'b1, 7'd0);
        checks++;
        if (clear_all !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_early: clear_all=%b required 0", clear_all);
        end
        @(posedge clk);
        #1;
        snap_req    = 1'b0;
        clr_on_read = 1'b0;
        cnt_flat    = '0;
        checks++;
        if (clear_all !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_pulse: clear_all=%b required 1", clear_all);
        end
        @(posedge clk);
        #1;
        checks++;
        if (clear_all !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_width: clear_all=%b required 0", clear_all);
        end
        wait_drain(60, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL clr_drain: %0d words left required 0", exp_data_q.size());
        end
        seq_model = seq_model + 8'd1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit extra;
        set_counters(32'd0, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b1;
        push_record(seq_model, 1'b0, 7'd0);
        push_record(seq_model + 8'd1, 1'b0, 7'd2);
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        for (int p = 0; p < 3; p++) begin
            @(posedge clk);
            #1;
            snap_req = 1'b1;
            @(posedge clk);
            #1;
            snap_req = 1'b0;
        end
        wait_drain(100, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL b2b_drain: %0d words left required 0", exp_data_q.size());
        end
        seq_model = seq_model + 8'd2;
        checks++;
        if (seq_num !== seq_model) begin
            errors++;
            $display("[TB] FAIL b2b_seq: seq=%0d required %0d", seq_num, seq_model);
        end
        extra = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("[TB] FAIL no_third_record: out_valid seen=1 required 0");
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_counters(32'd0, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b1;
        push_record(seq_model, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            out_data !== 32'd0 || seq_num !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%b busy=%b last=%b data=%h seq=%0d required 0 0 0 0 0",
                     out_valid, busy, out_last, out_data, seq_num);
        end
        exp_data_q.delete();
        exp_last_q.delete();
        seq_model = 8'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b1;
        push_record(seq_model, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        wait_drain(60, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL post_reset_drain: %0d words left required 0", exp_data_q.size());
        end
        seq_model = seq_model + 8'd1;
        checks++;
        if (seq_num !== seq_model) begin
            errors++;
            $display("[TB] FAIL post_reset_seq: seq=%0d required %0d", seq_num, seq_model);
        end
    endtask

    task automatic test_periodic();
        int  starts;
        int  last_c;
        bit  prev_valid;
        @(posedge clk);
        #1;
        reset_n2   = 1'b1;
        starts     = 0;
        last_c     = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 26000 && starts < 257; c++) begin
            @(negedge clk);
            if (out_valid2 && !prev_valid) begin
                checks++;
                if (out_data2 !== {8'hEC, 8'(starts), 8'd9, 8'd0}) begin
                    errors++;
                    $display("[TB] FAIL periodic_header: rec=%0d data=%h required %h",
                             starts, out_data2, {8'hEC, 8'(starts), 8'd9, 8'd0});
                end
                if (starts > 0) begin
                    checks++;
                    if (c - last_c != 100) begin
                        errors++;
                        $display("[TB] FAIL periodic_interval: rec=%0d interval=%0d required 100",
                                 starts, c - last_c);
                    end
                end
                last_c = c;
                starts++;
            end
            prev_valid = out_valid2;
        end
        checks++;
        if (starts != 257) begin
            errors++;
            $display("[TB] FAIL periodic_count: records=%0d required 257", starts);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_clr_on_read();
        test_back_to_back();
        test_reset_mid();
        test_periodic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
